// File: rtl/lc3b_branch_predictor_if.sv
// ID-query / WB-train bundle between the LC-3b pipeline and its branch predictor.
// The pipeline drives the master side and the predictor sits on the slave side.
interface lc3b_branch_predictor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             iIdBranch;
  logic [15:0]      iIdPC;
  logic             oIdBranchPredicted;
  logic [15:0]      oIdPredTarget;
  logic             iWbBranch;
  logic [15:0]      iWbPC;
  logic             iWbTaken;
  logic [15:0]      iWbTarget;
  logic             iWbMispredict;
  logic [CNT_W-1:0] oPredCount;
  logic [CNT_W-1:0] oMispredCount;

  modport master (
    output iIdBranch, iIdPC, iWbBranch, iWbPC, iWbTaken, iWbTarget, iWbMispredict,
    input  oIdBranchPredicted, oIdPredTarget, oPredCount, oMispredCount
  );

  modport slave (
    input  iIdBranch, iIdPC, iWbBranch, iWbPC, iWbTaken, iWbTarget, iWbMispredict,
    output oIdBranchPredicted, oIdPredTarget, oPredCount, oMispredCount
  );
endinterface

// File: rtl/lc3b_branch_predictor.sv
// LC-3b branch predictor: direct-mapped 2-bit PHT + tagged BTB, trained at WB.
// Optional gshare indexing of the PHT is enabled by defining LC3B_BP_GSHARE_EN.
module lc3b_branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  lc3b_branch_predictor_if.slave bp
);
  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = 15 - IDX_BITS;

  logic [1:0]       pht_q        [ENTRIES];
  logic             btb_valid_q  [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
  logic [15:0]      btb_target_q [ENTRIES];
  logic [CNT_W-1:0] pred_cnt_q;
  logic [CNT_W-1:0] misp_cnt_q;

  logic [IDX_BITS-1:0] id_bidx;
  logic [IDX_BITS-1:0] id_pidx;
  logic [TAG_W-1:0]    id_tag;
  logic [IDX_BITS-1:0] wb_bidx;
  logic [IDX_BITS-1:0] wb_pidx;
  logic [TAG_W-1:0]    wb_tag;
  logic                id_hit;
  logic                id_pred;
  logic [1:0]          pht_next;

  assign id_bidx = bp.iIdPC[IDX_BITS:1];
  assign id_tag  = bp.iIdPC[15:IDX_BITS+1];
  assign wb_bidx = bp.iWbPC[IDX_BITS:1];
  assign wb_tag  = bp.iWbPC[15:IDX_BITS+1];

`ifdef LC3B_BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;

  // Lookup and update both hash with the current (pre-shift) history.
  assign id_pidx = id_bidx ^ ghr_q;
  assign wb_pidx = wb_bidx ^ ghr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (bp.iWbBranch) begin
      ghr_q <= {ghr_q[IDX_BITS-2:0], bp.iWbTaken};
    end
  end
`else
  assign id_pidx = id_bidx;
  assign wb_pidx = wb_bidx;
`endif

  // Zero-latency lookup; reads registered state, so a same-cycle update is not seen.
  always_comb begin
    id_hit  = btb_valid_q[id_bidx] && (btb_tag_q[id_bidx] == id_tag);
    id_pred = rst_n && bp.iIdBranch && id_hit && pht_q[id_pidx][1];
  end

  assign bp.oIdBranchPredicted = id_pred;
  assign bp.oIdPredTarget      = id_pred ? btb_target_q[id_bidx] : 16'h0000;
  assign bp.oPredCount         = rst_n ? pred_cnt_q : '0;
  assign bp.oMispredCount      = rst_n ? misp_cnt_q : '0;

  // Saturating 2-bit counter step for the retiring branch.
  always_comb begin
    pht_next = pht_q[wb_pidx];
    if (bp.iWbTaken) begin
      if (pht_q[wb_pidx] != 2'd3) pht_next = pht_q[wb_pidx] + 2'd1;
    end else begin
      if (pht_q[wb_pidx] != 2'd0) pht_next = pht_q[wb_pidx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i]       <= 2'd1;
        btb_valid_q[i] <= 1'b0;
      end
      pred_cnt_q <= '0;
      misp_cnt_q <= '0;
    end else if (bp.iWbBranch) begin
      pht_q[wb_pidx] <= pht_next;
      if (bp.iWbTaken) btb_valid_q[wb_bidx] <= 1'b1;
      if (pred_cnt_q != '1) pred_cnt_q <= pred_cnt_q + CNT_W'(1);
      if (bp.iWbMispredict && (misp_cnt_q != '1)) misp_cnt_q <= misp_cnt_q + CNT_W'(1);
    end
  end

  // BTB payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (rst_n && bp.iWbBranch && bp.iWbTaken) begin
      btb_tag_q[wb_bidx]    <= wb_tag;
      btb_target_q[wb_bidx] <= bp.iWbTarget;
    end
  end

  logic unused_pc_lsb;
  assign unused_pc_lsb = bp.iIdPC[0] ^ bp.iWbPC[0];
endmodule

// File: tb/tb_lc3b_branch_predictor.sv
// Scoreboard bench for lc3b_branch_predictor: stimulus queues expectations, a negedge monitor checks.
module tb_lc3b_branch_predictor;
  localparam int unsigned IDX_BITS = 4;
  localparam int unsigned CNT_W    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_branch_predictor_if #(.CNT_W(CNT_W)) bp ();

  lc3b_branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  typedef struct {
    string       name;
    logic        pred;
    logic [15:0] tgt;
    logic [15:0] pcnt;
    logic [15:0] mcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic cmp(input string n, input string field, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h at %0t", n, field, act, req, $time);
  endtask

  // Monitor: outputs are combinational, so they are presented every cycle once stimulus settles.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "pred",   16'(bp.oIdBranchPredicted), 16'(e.pred));
      cmp(e.name, "target", bp.oIdPredTarget,           e.tgt);
      cmp(e.name, "pcnt",   bp.oPredCount,              e.pcnt);
      cmp(e.name, "mcnt",   bp.oMispredCount,           e.mcnt);
    end
  end

  task automatic drive(input logic r, input logic idb, input logic [15:0] idpc,
                       input logic wbb, input logic [15:0] wbpc, input logic tk,
                       input logic [15:0] tgt, input logic mp);
    @(posedge clk);
    #1;
    rst_n            = r;
    bp.iIdBranch     = idb;
    bp.iIdPC         = idpc;
    bp.iWbBranch     = wbb;
    bp.iWbPC         = wbpc;
    bp.iWbTaken      = tk;
    bp.iWbTarget     = tgt;
    bp.iWbMispredict = mp;
  endtask

  task automatic expect_out(input string n, input logic p, input logic [15:0] t,
                            input logic [15:0] pc, input logic [15:0] mc);
    exp_t e;
    e.name = n; e.pred = p; e.tgt = t; e.pcnt = pc; e.mcnt = mc;
    exp_q.push_back(e);
  endtask

  initial begin
    bp.iIdBranch = 1'b0; bp.iIdPC = '0; bp.iWbBranch = 1'b0; bp.iWbPC = '0;
    bp.iWbTaken = 1'b0; bp.iWbTarget = '0; bp.iWbMispredict = 1'b0;

    // Reset with a live WB pulse and ID query: everything reads zero.
    drive(0, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 1); expect_out("rst_hold0", 0, 16'h0, 0, 0);
    drive(0, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 1); expect_out("rst_hold1", 0, 16'h0, 0, 0);
    drive(1, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("post_rst",  0, 16'h0, 0, 0);

`ifdef LC3B_BP_GSHARE_EN
    // Alternating T/NT at one PC: warm up, then prediction must track the pattern exactly.
    for (int k = 0; k < 8; k++)
      drive(1, 0, 16'h0, 1, 16'h0040, 1'((k % 2) == 0), 16'h0100, 0);
    for (int k = 8; k < 40; k++) begin
      logic tk;
      tk = 1'((k % 2) == 0);
      drive(1, 1, 16'h0040, 1, 16'h0040, tk, 16'h0100, 0);
      #1;
      bp.iWbMispredict = (bp.oIdBranchPredicted !== tk);
      expect_out("gshare_alt", tk, tk ? 16'h0100 : 16'h0000, 16'(k), 16'h0);
    end
    drive(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0); expect_out("gshare_final", 0, 16'h0, 16'd40, 16'h0);
`else
    // Training toward taken: one pulse 1->2 is enough to predict.
    drive(1, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 1); expect_out("train1_same", 0, 16'h0, 0, 0);
    drive(1, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("one_pulse",  1, 16'h0100, 1, 1);
    drive(1, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 0); expect_out("train2_same", 1, 16'h0100, 1, 1);
    drive(1, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("strong_t",   1, 16'h0100, 2, 1);
    // Four not-taken pulses from strong-T: 3->2->1->0->0.
    drive(1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0, 1);    expect_out("nt1", 1, 16'h0100, 2, 1);
    drive(1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0, 1);    expect_out("nt2", 1, 16'h0100, 3, 2);
    drive(1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0, 1);    expect_out("nt3", 0, 16'h0, 4, 3);
    drive(1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0, 1);    expect_out("nt4", 0, 16'h0, 5, 4);
    drive(1, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("floor_idle", 0, 16'h0, 6, 5);
    // Floor held at 0: two taken pulses needed to predict again; read-before-write each cycle.
    drive(1, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 0); expect_out("rbw_from0", 0, 16'h0, 6, 5);
    drive(1, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 0); expect_out("rbw_from1", 0, 16'h0, 7, 5);
    drive(1, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("rbw_next",  1, 16'h0100, 8, 5);
    // Alias 0x0060 shares index 0 but has a different tag.
    drive(1, 1, 16'h0060, 0, 16'h0, 0, 16'h0, 0);       expect_out("alias_miss", 0, 16'h0, 8, 5);
    drive(1, 0, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("no_branch",  0, 16'h0, 8, 5);
    drive(1, 1, 16'h0060, 1, 16'h0060, 1, 16'h0200, 0); expect_out("alias_write_same", 0, 16'h0, 8, 5);
    drive(1, 1, 16'h0060, 0, 16'h0, 0, 16'h0, 0);       expect_out("alias_hit",   1, 16'h0200, 9, 5);
    drive(1, 1, 16'h0040, 0, 16'h0, 0, 16'h0, 0);       expect_out("alias_evict", 0, 16'h0, 9, 5);
    drive(1, 1, 16'h0042, 0, 16'h0, 0, 16'h0, 0);       expect_out("idx1_invalid", 0, 16'h0, 9, 5);
    // Counter saturation.
    for (int i = 0; i < 70000; i++)
      drive(1, 0, 16'h0, 1, 16'h0080, 0, 16'h0, 1);
    drive(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);          expect_out("sat", 0, 16'h0, 16'hFFFF, 16'hFFFF);
    // Reset overrides a coincident update.
    drive(0, 1, 16'h0060, 1, 16'h0060, 1, 16'h0300, 1); expect_out("in_reset",  0, 16'h0, 0, 0);
    drive(1, 1, 16'h0060, 0, 16'h0, 0, 16'h0, 0);       expect_out("rst_clear", 0, 16'h0, 0, 0);
    // Every PHT entry restarts at weak-NT: one taken pulse each makes all predict.
    for (int i = 0; i < 16; i++)
      drive(1, 0, 16'h0, 1, 16'(i * 2), 1, 16'h1000 + 16'(i), 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 16'(i * 2), 0, 16'h0, 0, 16'h0, 0);
      expect_out("pht_init", 1, 16'h1000 + 16'(i), 16, 0);
    end
    drive(1, 1, 16'h000A, 1, 16'h000A, 0, 16'h0, 0);    expect_out("idx5_nt_same", 1, 16'h1005, 16, 0);
    drive(1, 1, 16'h000A, 0, 16'h0, 0, 16'h0, 0);       expect_out("idx5_weak_nt", 0, 16'h0, 17, 0);
`endif

    drive(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
